// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and widths for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LDUSE  = 2'd1,
    ST_FREEZE = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [15:0] NOP_INSTR   = 16'h1800;
  localparam int          STALL_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with increment enable
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/freeze/halt control for a 5-stage pipeline
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_STALL = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             id_rs,
  input  logic                   id_rs_used,
  input  logic [2:0]             id_rt,
  input  logic                   id_rt_used,
  input  logic [2:0]             ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   branch_taken,
  input  logic                   imem_busy,
  input  logic                   dmem_busy,
  input  logic                   halt_id,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   ex_mem_en,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] LU_LOAD = 2'(LU_STALL - 1);

  state_t     r_state, w_state_nxt;
  state_t     r_ret, w_ret_nxt;
  state_t     w_eval;
  logic [1:0] r_count, w_count_nxt;
  logic       w_lu;
  logic       w_stall_inc;

  assign w_lu = ex_mem_read &
                ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));

  // A released freeze replays the cycle as the saved state would have seen it.
  assign w_eval = (r_state == ST_FREEZE) ? r_ret : r_state;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b1;
    w_state_nxt  = r_state;
    w_ret_nxt    = r_ret;
    w_count_nxt  = r_count;

    if ((w_eval != ST_HALTED) && dmem_busy) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      ex_mem_en   = 1'b0;
      w_state_nxt = ST_FREEZE;
      w_ret_nxt   = w_eval;
    end else begin
      case (w_eval)
        ST_RUN: begin
          w_state_nxt = ST_RUN;
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (w_lu) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            if (LU_STALL > 1) begin
              w_state_nxt = ST_LDUSE;
              w_count_nxt = LU_LOAD;
            end
          end else if (halt_id) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            w_state_nxt  = ST_HALTED;
          end else if (imem_busy) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        ST_LDUSE: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          w_count_nxt  = r_count - 2'd1;
          w_state_nxt  = (w_count_nxt == 2'd0) ? ST_RUN : ST_LDUSE;
        end
        ST_HALTED: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          ex_mem_en    = ~dmem_busy;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end

    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_ret   <= ST_RUN;
      r_count <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign halted      = (r_state == ST_HALTED);
  assign w_stall_inc = ~pc_en & (r_state != ST_HALTED);

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_inc(w_stall_inc),
    .o_cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_rs_used, id_rt_used, ex_mem_read;
  logic       branch_taken, imem_busy, dmem_busy, halt_id;

  logic        pc_en1, if_id_en1, if_id_flush1, id_ex_bubble1, ex_mem_en1, halted1;
  logic        pc_en3, if_id_en3, if_id_flush3, id_ex_bubble3, ex_mem_en3, halted3;
  logic [15:0] stall_cnt1, stall_cnt3;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LU_STALL(1)) u_dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt),
    .id_rt_used(id_rt_used), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .halt_id(halt_id), .pc_en(pc_en1), .if_id_en(if_id_en1), .if_id_flush(if_id_flush1),
    .id_ex_bubble(id_ex_bubble1), .ex_mem_en(ex_mem_en1), .halted(halted1),
    .stall_cnt(stall_cnt1)
  );

  pipe_hazard_ctrl #(.LU_STALL(3)) u_dut3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt),
    .id_rt_used(id_rt_used), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .halt_id(halt_id), .pc_en(pc_en3), .if_id_en(if_id_en3), .if_id_flush(if_id_flush3),
    .id_ex_bubble(id_ex_bubble3), .ex_mem_en(ex_mem_en3), .halted(halted3),
    .stall_cnt(stall_cnt3)
  );

  // Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, halted}
  localparam logic [5:0] O_IDLE  = 6'b110010;
  localparam logic [5:0] O_STALL = 6'b000110;
  localparam logic [5:0] O_BR    = 6'b111110;
  localparam logic [5:0] O_FRZ   = 6'b000000;
  localparam logic [5:0] O_IMEM  = 6'b011010;
  localparam logic [5:0] O_RST   = 6'b001100;
  localparam logic [5:0] O_HALT  = 6'b000111;
  localparam logic [5:0] O_HALTB = 6'b000101;

  typedef struct {
    string      tag;
    int         dut;
    logic [5:0] outs;
  } exp_t;

  typedef struct {
    string      tag;
    logic [2:0] rs, rt, rd;
    logic       rsu, rtu, mr, br, im, dm, ht;
    logic [5:0] outs;
    logic       hnext;
  } vec_t;

  exp_t sb[$];
  vec_t vt[13];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [5:0] get_outs(input int d);
    if (d == 3) return {pc_en3, if_id_en3, if_id_flush3, id_ex_bubble3, ex_mem_en3, halted3};
    return {pc_en1, if_id_en1, if_id_flush1, id_ex_bubble1, ex_mem_en1, halted1};
  endfunction

  function automatic vec_t mk(input string tag, input logic [2:0] rs, input logic rsu,
                              input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                              input logic mr, input logic br, input logic im, input logic dm,
                              input logic ht, input logic [5:0] outs, input logic hnext);
    vec_t v;
    v.tag = tag; v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu; v.rd = rd;
    v.mr = mr; v.br = br; v.im = im; v.dm = dm; v.ht = ht; v.outs = outs; v.hnext = hnext;
    return v;
  endfunction

  task automatic clear_in();
    id_rs = 3'd0; id_rs_used = 1'b0; id_rt = 3'd0; id_rt_used = 1'b0; ex_rd = 3'd0;
    ex_mem_read = 1'b0; branch_taken = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
    halt_id = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rs_used = v.rsu; id_rt = v.rt; id_rt_used = v.rtu; ex_rd = v.rd;
    ex_mem_read = v.mr; branch_taken = v.br; imem_busy = v.im; dmem_busy = v.dm;
    halt_id = v.ht;
  endtask

  task automatic push(input string tag, input int d, input logic [5:0] o);
    exp_t e;
    e.tag = tag; e.dut = d; e.outs = o;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    logic [5:0] a;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = get_outs(e.dut);
      total++;
      if (a !== e.outs) begin
        bad++;
        $display("FAIL %s (dut%0d): got %b want %b", e.tag, e.dut, a, e.outs);
      end
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_in();
    push("reset_outs", 1, O_RST);
    push("reset_outs", 3, O_RST);
    sample();
    chk16("reset_cnt1", stall_cnt1, 16'h0000);
    chk16("reset_cnt3", stall_cnt3, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [5:0] s2_exp [6];
    logic       s2_dm  [6];

    clear_in();
    vt[0]  = mk("idle",      3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, O_IDLE,  0);
    vt[1]  = mk("lu_rs",     3'd3, 1, 3'd1, 0, 3'd3, 1, 0, 0, 0, 0, O_STALL, 0);
    vt[2]  = mk("lu_rt",     3'd5, 0, 3'd5, 1, 3'd5, 1, 0, 0, 0, 0, O_STALL, 0);
    vt[3]  = mk("rs_unused", 3'd3, 0, 3'd2, 1, 3'd3, 1, 0, 0, 0, 0, O_IDLE,  0);
    vt[4]  = mk("no_load",   3'd3, 1, 3'd3, 1, 3'd3, 0, 0, 0, 0, 0, O_IDLE,  0);
    vt[5]  = mk("lu_r0",     3'd0, 1, 3'd7, 0, 3'd0, 1, 0, 0, 0, 0, O_STALL, 0);
    vt[6]  = mk("br_halt",   3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0, 0, 1, O_BR,    0);
    vt[7]  = mk("br_lu",     3'd4, 1, 3'd0, 0, 3'd4, 1, 1, 0, 0, 0, O_BR,    0);
    vt[8]  = mk("dmem_br",   3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 1, 1, 1, O_FRZ,   0);
    vt[9]  = mk("imem",      3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 0, O_IMEM,  0);
    vt[10] = mk("halt_imem", 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 1, O_STALL, 1);
    vt[11] = mk("lu_halt",   3'd6, 1, 3'd0, 0, 3'd6, 1, 0, 0, 0, 1, O_STALL, 0);
    vt[12] = mk("halt",      3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 1, O_STALL, 1);

    for (int i = 0; i < 13; i++) begin
      do_reset();
      drive(vt[i]);
      push(vt[i].tag, 1, vt[i].outs);
      sample();
      @(negedge clk);
      total++;
      if (halted1 !== vt[i].hnext) begin
        bad++;
        $display("FAIL %s_halted_next: got %b want %b", vt[i].tag, halted1, vt[i].hnext);
      end
    end

    // Load-use with a single stall cycle
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_used = 1'b1;
    push("lu1_stall", 1, O_STALL);
    sample();
    @(negedge clk);
    clear_in();
    push("lu1_after", 1, O_IDLE);
    sample();
    chk16("lu1_cnt", stall_cnt1, 16'd1);

    // Load-use with three stall cycles and a 2-cycle data-memory freeze
    s2_exp = '{O_STALL, O_FRZ, O_FRZ, O_STALL, O_STALL, O_IDLE};
    s2_dm  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      clear_in();
      if (c == 0) begin
        ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_used = 1'b1;
      end
      dmem_busy = s2_dm[c];
      push($sformatf("lu3_c%0d", c), 3, s2_exp[c]);
      sample();
      @(negedge clk);
    end
    #1;
    chk16("lu3_cnt", stall_cnt3, 16'd5);

    // A branch held through a freeze is acted on once, after release
    do_reset();
    branch_taken = 1'b1; dmem_busy = 1'b1;
    push("frz_br_hold", 1, O_FRZ);
    sample();
    @(negedge clk);
    dmem_busy = 1'b0;
    push("frz_br_release", 1, O_BR);
    sample();
    @(negedge clk);
    branch_taken = 1'b0;
    push("frz_br_after", 1, O_IDLE);
    sample();

    // Asynchronous reset in the middle of LDUSE
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 3'd2; id_rt = 3'd2; id_rt_used = 1'b1;
    push("ldrst_stall", 3, O_STALL);
    sample();
    @(negedge clk);
    clear_in();
    push("ldrst_ldsue", 3, O_STALL);
    sample();
    #2;
    rst = 1'b1;
    push("ldrst_async", 3, O_RST);
    sample();
    chk16("ldrst_cnt", stall_cnt3, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    push("ldrst_run", 3, O_IDLE);
    sample();

    // HALT, drain behaviour, and asynchronous exit through reset
    do_reset();
    halt_id = 1'b1;
    push("halt_first", 1, O_STALL);
    sample();
    @(negedge clk);
    halt_id = 1'b0;
    for (int c = 0; c < 10; c++) begin
      dmem_busy = c[0];
      push($sformatf("halted_c%0d", c), 1, c[0] ? O_HALTB : O_HALT);
      sample();
      @(negedge clk);
    end
    dmem_busy = 1'b0;
    chk16("halt_cnt", stall_cnt1, 16'd1);
    #2;
    rst = 1'b1;
    push("halt_rst", 1, O_RST);
    sample();
    chk16("halt_rst_cnt", stall_cnt1, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    push("halt_rst_run", 1, O_IDLE);
    sample();

    // Instruction-memory wait inserts NOPs without stopping decode
    do_reset();
    imem_busy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      push($sformatf("imem_c%0d", c), 1, O_IMEM);
      sample();
      @(negedge clk);
    end
    imem_busy = 1'b0;
    push("imem_after", 1, O_IDLE);
    sample();
    chk16("imem_cnt", stall_cnt1, 16'd4);

    // Saturation of the stall counter
    do_reset();
    imem_busy = 1'b1;
    repeat (65534) @(negedge clk);
    #1;
    chk16("sat_fffe", stall_cnt1, 16'hFFFE);
    repeat (3) @(negedge clk);
    #1;
    chk16("sat_ffff", stall_cnt1, 16'hFFFF);
    imem_busy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
